seq_div: RTL and testbench

- Iterative, parametrised integer divider: unsigned restoring division, STEPS_PER_CYCLE quotient bits per clock.
- Successor to the single-step combinational divider stage; it reuses that step in a loop under a control FSM.
- Valid/ready handshake on input and output; sits in the FP divider datapath for mantissa division and is usable standalone.

---
 rtl/div_pkg.sv | 26 ++
 rtl/seq_div_if.sv | 43 ++++
 rtl/div_step.sv | 29 ++
 rtl/seq_div.sv | 156 +++++++++++++++
 tb/tb_seq_div.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and elaboration helpers for the seq_div iterative divider.
//   state_t     - control FSM states (FIXUP is only reachable when SEQ_DIV_SIGNED_EN is defined)
//   iters()     - clock iterations needed for a WIDTH-bit division at a given unroll factor
//   cnt_width() - iteration counter width, never less than one bit
//   DEF_CNT_W   - counter width for the default 32-bit, one-step-per-clock build
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } state_t;

  function automatic int iters(input int width, input int steps);
    return (steps > 0) ? (width / steps) : 1;
  endfunction

  // A single-iteration configuration still needs a one-bit counter.
  function automatic int cnt_width(input int n_iters);
    return (n_iters > 1) ? $clog2(n_iters) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(iters(32, 1));

endpackage

// File: rtl/seq_div_if.sv
// seq_div_if: operand/result handshake bundle for seq_div.
//   in_valid/in_ready    - operand handshake (dividend, divisor)
//   out_valid/out_ready  - result handshake (quotient, remainder, div_by_zero)
//   is_signed            - present only when SEQ_DIV_SIGNED_EN is defined
//   master modport: the producer/consumer side; slave modport: the divider.
interface seq_div_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef SEQ_DIV_SIGNED_EN
  logic             is_signed;

  modport master (
    output in_valid, dividend, divisor, out_ready, is_signed,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready, is_signed,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
`endif

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   r, q, d        - partial remainder, quotient/shift register, divisor
//   r_next, q_next - remainder and shift register after shifting in q's MSB
//                    and conditionally subtracting d
// Relies on r < d on entry, which the restoring loop maintains.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // One extra bit keeps the shifted remainder (< 2*d) from overflowing.
  assign shifted = {r, q[WIDTH-1]};
  assign diff    = shifted - {1'b0, d};
  // Since shifted < 2*d, the top bit of diff is set exactly when shifted < d.
  assign ge      = ~diff[WIDTH];

  assign r_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_div.sv
// seq_div: iterative unsigned restoring divider, STEPS_PER_CYCLE quotient bits per clock.
//   clk, rst - rising-edge clock, asynchronous active-high reset
//   bus      - seq_div_if.slave: operands in (valid/ready), quotient/remainder/
//              div_by_zero out (valid/ready); one operation in flight.
// Parameters: WIDTH (>=2), STEPS_PER_CYCLE (must divide WIDTH).
// Optional macro SEQ_DIV_SIGNED_EN: adds is_signed; signed operands are divided as
// magnitudes and a one-clock FIXUP state restores the signs afterwards.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic      clk,
  input logic      rst,
  seq_div_if.slave bus
);

  localparam int ITERS = iters(WIDTH, STEPS_PER_CYCLE);
  localparam int CNT_W = cnt_width(ITERS);

  if (WIDTH < 2 || STEPS_PER_CYCLE < 1 || (WIDTH % STEPS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("seq_div: WIDTH must be >= 2 and a multiple of STEPS_PER_CYCLE");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] cnt;
  logic             dbz;
  logic             zero_div;
  logic [WIDTH-1:0] n_mag;
  logic [WIDTH-1:0] d_mag;

  assign zero_div = (bus.divisor == '0);

`ifdef SEQ_DIV_SIGNED_EN
  logic n_neg;
  logic d_neg;
  logic signed_op;
  logic neg_q;
  logic neg_r;

  assign n_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign d_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign n_mag = n_neg ? (-bus.dividend) : bus.dividend;
  assign d_mag = d_neg ? (-bus.divisor) : bus.divisor;
`else
  assign n_mag = bus.dividend;
  assign d_mag = bus.divisor;
`endif

  // Unrolled restoring steps: stage 0 is the registered state, the last stage is
  // what RUN writes back each clock.
  logic [WIDTH-1:0] r_chain [STEPS_PER_CYCLE+1];
  logic [WIDTH-1:0] q_chain [STEPS_PER_CYCLE+1];

  assign r_chain[0] = r_reg;
  assign q_chain[0] = q_reg;

  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r_chain[i]),
      .q      (q_chain[i]),
      .d      (d_reg),
      .r_next (r_chain[i+1]),
      .q_next (q_chain[i+1])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.in_valid) state_next = zero_div ? DONE : RUN;
      RUN:   if (cnt == '0) begin
`ifdef SEQ_DIV_SIGNED_EN
               state_next = signed_op ? FIXUP : DONE;
`else
               state_next = DONE;
`endif
             end
      FIXUP: state_next = DONE;
      DONE:  if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, because the result ports are
  // driven straight from them and must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      cnt       <= '0;
      dbz       <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      signed_op <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          cnt   <= CNT_W'(ITERS - 1);
          d_reg <= d_mag;
          dbz   <= zero_div;
          if (zero_div) begin
            // Divide-by-zero result is formed at accept; RUN is skipped.
            q_reg <= '1;
            r_reg <= bus.dividend;
          end else begin
            q_reg <= n_mag;
            r_reg <= '0;
          end
`ifdef SEQ_DIV_SIGNED_EN
          signed_op <= bus.is_signed & ~zero_div;
          neg_q     <= n_neg ^ d_neg;
          neg_r     <= n_neg;
`endif
        end
        RUN: begin
          q_reg <= q_chain[STEPS_PER_CYCLE];
          r_reg <= r_chain[STEPS_PER_CYCLE];
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
`ifdef SEQ_DIV_SIGNED_EN
        FIXUP: begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          if (neg_q) q_reg <= -q_reg;
          if (neg_r) r_reg <= -r_reg;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = q_reg;
  assign bus.remainder   = r_reg;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: self-checking bench for seq_div.
// Two instances share clk/rst: index 0 runs one step per clock (32 iterations),
// index 1 runs four steps per clock (8 iterations). A cycle-level reference model
// computes results with plain arithmetic and predicts handshake timing; a compare
// process checks every output on every falling edge, and directed runs add
// hand-computed literal expectations.
// Latencies are counted in rising edges after the accept edge: a normal result
// appears ITERS edges later, a divide-by-zero result is already valid in the
// cycle right after the accept edge (0 further edges).
`timescale 1ns/1ps
module tb_seq_div;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench-side drive and observe arrays, one slot per DUT.
  logic         iv   [2];
  logic [W-1:0] nn   [2];
  logic [W-1:0] dd   [2];
  logic         sg   [2];
  logic         ordy [2];
  logic         rdy  [2];
  logic         ov   [2];
  logic         dz   [2];
  logic [W-1:0] qq   [2];
  logic [W-1:0] rr   [2];

  seq_div_if #(.WIDTH(W)) a_if ();
  seq_div_if #(.WIDTH(W)) b_if ();

  seq_div #(.WIDTH(W), .STEPS_PER_CYCLE(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  seq_div #(.WIDTH(W), .STEPS_PER_CYCLE(4)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  assign a_if.in_valid  = iv[0];
  assign a_if.dividend  = nn[0];
  assign a_if.divisor   = dd[0];
  assign a_if.out_ready = ordy[0];
  assign b_if.in_valid  = iv[1];
  assign b_if.dividend  = nn[1];
  assign b_if.divisor   = dd[1];
  assign b_if.out_ready = ordy[1];
`ifdef SEQ_DIV_SIGNED_EN
  assign a_if.is_signed = sg[0];
  assign b_if.is_signed = sg[1];
`endif

  assign rdy[0] = a_if.in_ready;
  assign ov[0]  = a_if.out_valid;
  assign qq[0]  = a_if.quotient;
  assign rr[0]  = a_if.remainder;
  assign dz[0]  = a_if.div_by_zero;
  assign rdy[1] = b_if.in_ready;
  assign ov[1]  = b_if.out_valid;
  assign qq[1]  = b_if.quotient;
  assign rr[1]  = b_if.remainder;
  assign dz[1]  = b_if.div_by_zero;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic res_t model_div(input logic [W-1:0] n, input logic [W-1:0] d, input logic s);
    res_t   o;
    longint sn;
    longint sd;
    if (d == '0) begin
      o.q = '1;
      o.r = n;
      o.z = 1'b1;
    end else if (!s) begin
      o.q = n / d;
      o.r = n % d;
      o.z = 1'b0;
    end else begin
      // 64-bit arithmetic sidesteps the MIN_INT / -1 overflow; truncation wraps it back.
      sn  = longint'($signed(n));
      sd  = longint'($signed(d));
      o.q = W'(sn / sd);
      o.r = W'(sn % sd);
      o.z = 1'b0;
    end
    return o;
  endfunction

  function automatic int iters_of(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic int lat_edges(input logic [W-1:0] d, input logic s, input int it);
    if (d == '0) return 0;
    return it + (s ? 1 : 0);
  endfunction

  logic busy   [2];
  logic evalid [2];
  int   cd     [2];
  res_t eres   [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        busy[i]   <= 1'b0;
        evalid[i] <= 1'b0;
        cd[i]     <= 0;
        eres[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!busy[i]) begin
          if (iv[i]) begin
            busy[i]   <= 1'b1;
            eres[i]   <= model_div(nn[i], dd[i], sg[i]);
            cd[i]     <= lat_edges(dd[i], sg[i], iters_of(i));
            evalid[i] <= (lat_edges(dd[i], sg[i], iters_of(i)) == 0);
          end
        end else if (evalid[i]) begin
          if (ordy[i]) begin
            busy[i]   <= 1'b0;
            evalid[i] <= 1'b0;
          end
        end else begin
          cd[i] <= cd[i] - 1;
          if (cd[i] == 1) evalid[i] <= 1'b1;
        end
      end
    end
  end

  // Every cycle: handshake outputs always; result fields whenever a result is due.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d in_ready", i), 64'(rdy[i]), 64'(!busy[i]));
        check($sformatf("dut%0d out_valid", i), 64'(ov[i]), 64'(evalid[i]));
        if (evalid[i]) begin
          check($sformatf("dut%0d quotient", i), 64'(qq[i]), 64'(eres[i].q));
          check($sformatf("dut%0d remainder", i), 64'(rr[i]), 64'(eres[i].r));
          check($sformatf("dut%0d div_by_zero", i), 64'(dz[i]), 64'(eres[i].z));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Presents operands for one edge (the DUT is idle when called), then scrambles them.
  task automatic issue(input int i, input logic [W-1:0] n, input logic [W-1:0] d, input logic s);
    @(negedge clk);
    iv[i] = 1'b1;
    nn[i] = n;
    dd[i] = d;
    sg[i] = s;
    @(posedge clk);
    #1;
    iv[i] = 1'b0;
    nn[i] = $urandom;
    dd[i] = $urandom;
    sg[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, output int lat);
    lat = 0;
    while (!ov[i] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input int i, input logic [W-1:0] n, input logic [W-1:0] d, input logic s,
                        input int exp_lat, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input string tag);
    int lat;
    issue(i, n, d, s);
    wait_valid(i, lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " quotient"}, 64'(qq[i]), 64'(eq));
    check({tag, " remainder"}, 64'(rr[i]), 64'(er));
    check({tag, " div_by_zero"}, 64'(dz[i]), 64'(ez));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           lat;
    int           inv_bad;
    logic [W-1:0] n;
    logic [W-1:0] d;
    longint unsigned prod;

    for (int i = 0; i < 2; i++) begin
      iv[i]   = 1'b0;
      nn[i]   = '0;
      dd[i]   = '0;
      sg[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset in_ready", 64'(rdy[0]), 64'(1));
    check("reset out_valid", 64'(ov[0]), 64'(0));
    check("reset quotient", 64'(qq[0]), 64'(0));
    check("reset remainder", 64'(rr[0]), 64'(0));
    check("reset div_by_zero", 64'(dz[0]), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Basic unsigned cases on the one-step instance.
    run_op(0, 32'd100, 32'd7, 1'b0, 32, 32'd14, 32'd2, 1'b0, "100/7");
    run_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32, 32'hFFFF_FFFF, 32'd0, 1'b0, "max/1");
    run_op(0, 32'd5, 32'd9, 1'b0, 32, 32'd0, 32'd5, 1'b0, "5/9");
    run_op(0, 32'h1234, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'h1234, 1'b1, "0x1234/0");
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32, 32'd1, 32'd0, 1'b0, "max/max");

    // Backpressure: result held for 10 cycles while in_valid is waved at a busy DUT.
    ordy[0] = 1'b0;
    issue(0, 32'd1000, 32'd3, 1'b0);
    wait_valid(0, lat);
    check("bp latency", 64'(lat), 64'(32));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      iv[0] = 1'b1;
      nn[0] = $urandom;
      dd[0] = $urandom;
    end
    #1;
    check("bp held quotient", 64'(qq[0]), 64'(333));
    check("bp held remainder", 64'(rr[0]), 64'(1));
    check("bp in_ready low", 64'(rdy[0]), 64'(0));
    @(negedge clk);
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp release idle", 64'(rdy[0]), 64'(1));
    check("bp release out_valid", 64'(ov[0]), 64'(0));
    run_op(0, 32'd77, 32'd7, 1'b0, 32, 32'd11, 32'd0, 1'b0, "after bp 77/7");

    // Asynchronous reset in the 15th RUN cycle discards the operation.
    issue(0, 32'd12345, 32'd17, 1'b0);
    repeat (14) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun rst out_valid", 64'(ov[0]), 64'(0));
    check("midrun rst in_ready", 64'(rdy[0]), 64'(1));
    check("midrun rst quotient", 64'(qq[0]), 64'(0));
    check("midrun rst remainder", 64'(rr[0]), 64'(0));
    check("midrun rst div_by_zero", 64'(dz[0]), 64'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    run_op(0, 32'd1000, 32'd10, 1'b0, 32, 32'd100, 32'd0, 1'b0, "after rst 1000/10");

`ifdef SEQ_DIV_SIGNED_EN
    run_op(0, 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "s -7/2");
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0, 1'b0, "s min/-1");
    run_op(0, 32'd7, 32'hFFFF_FFFE, 1'b1, 33, 32'hFFFF_FFFD, 32'd1, 1'b0, "s 7/-2");
    run_op(0, 32'hFFFF_FFFB, 32'd0, 1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, "s -5/0");
    run_op(0, 32'hFFFF_FFF9, 32'd2, 1'b0, 32, 32'h7FFF_FFFC, 32'd1, 1'b0, "u 0xfffffff9/2");
    run_op(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 9, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, "b s -7/2");
`endif

    // Four-steps-per-clock instance: literals, then random pairs.
    run_op(1, 32'd100, 32'd7, 1'b0, 8, 32'd14, 32'd2, 1'b0, "b 100/7");
    run_op(1, 32'd42, 32'd0, 1'b0, 0, 32'hFFFF_FFFF, 32'd42, 1'b1, "b 42/0");

    inv_bad = 0;
    for (int k = 0; k < 1000; k++) begin
      n = $urandom;
      d = $urandom >> $urandom_range(0, 31);
      if (d == '0) d = 32'd1;
      issue(1, n, d, 1'b0);
      wait_valid(1, lat);
      prod = longint'(qq[1]) * longint'(d) + longint'(rr[1]);
      if (lat != 8 || prod != longint'(n) || rr[1] >= d) inv_bad++;
      @(posedge clk);
      #1;
    end
    check("b random invariant/latency violations", 64'(inv_bad), 64'(0));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
